// File: rtl/lfsr_rand_range.sv
// Bounded pseudo-random value source: Fibonacci LFSR plus rejection sampling into 0..RANGE-1.
// Latency: req accepted at edge k, valid at edge k+1 (accepted candidate) up to edge k+MAX_TRY (fallback).
// Backpressure: none; req is only sampled in IDLE, is dropped while busy, and valid is a one-cycle pulse.
module lfsr_rand_range #(
  parameter int               WIDTH      = 7,
  parameter logic [WIDTH-1:0] TAPS       = 7'b1010100,
  parameter logic [WIDTH-1:0] SEED       = 7'b0000101,
  parameter int               OUT_W      = 2,
  parameter int               RANGE      = 3,
  parameter int               MAX_TRY    = 4,
  parameter logic [WIDTH-1:0] RESEED_PAT = 7'd8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             req,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [OUT_W-1:0] q,
  output logic             valid,
  output logic             busy,
  output logic             reseeded,
  output logic [WIDTH-1:0] lfsr_state
);

  localparam int TRY_W = $clog2(MAX_TRY + 1);
  localparam logic [TRY_W-1:0] LAST_TRY  = TRY_W'(MAX_TRY - 1);
  // One extra bit so RANGE == 2^OUT_W is representable in the compare.
  localparam logic [OUT_W:0]   RANGE_V   = (OUT_W + 1)'(RANGE);
  localparam logic [OUT_W-1:0] MSB_MASK  = OUT_W'(1) << (OUT_W - 1);

  typedef enum logic {IDLE, GEN} state_t;

  state_t           state, state_n;
  logic [TRY_W-1:0] tries, tries_n;
  logic [WIDTH-1:0] lfsr, lfsr_n;
  logic [OUT_W-1:0] q_n;
  logic             valid_n;
  logic             reseeded_n;
  logic             step_en;
  logic [OUT_W-1:0] cand;
  logic [WIDTH-1:0] step_val;
  logic             at_pat;

  // Candidate is always taken from the pre-step (and pre-load) LFSR contents.
  assign cand     = lfsr[OUT_W-1:0];
  assign at_pat   = (lfsr == RESEED_PAT);
  assign step_val = at_pat ? SEED : {lfsr[WIDTH-2:0], ^(lfsr & TAPS)};

  assign busy       = (state == GEN);
  assign lfsr_state = lfsr;

  // Next-state, candidate acceptance and LFSR update selection.
  always_comb begin
    state_n    = state;
    tries_n    = tries;
    q_n        = q;
    valid_n    = 1'b0;
    step_en    = 1'b0;
    lfsr_n     = lfsr;
    reseeded_n = 1'b0;

    case (state)
      IDLE: begin
        step_en = enable;
        if (req) begin
          state_n = GEN;
          tries_n = '0;
        end
      end
      GEN: begin
        step_en = 1'b1;
        if ({1'b0, cand} < RANGE_V) begin
          q_n     = cand;
          valid_n = 1'b1;
          state_n = IDLE;
        end else if (tries == LAST_TRY) begin
          // Clearing the MSB always lands inside the legal range since RANGE >= 2^(OUT_W-1).
          q_n     = cand & ~MSB_MASK;
          valid_n = 1'b1;
          state_n = IDLE;
        end else begin
          tries_n = tries + TRY_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    // A seed load wins over stepping; a zero seed would lock the LFSR, so substitute SEED.
    if (seed_load) begin
      lfsr_n = (seed_in == '0) ? SEED : seed_in;
    end else if (step_en) begin
      lfsr_n     = step_val;
      reseeded_n = at_pat;
    end
  end

  // State, LFSR and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      tries    <= '0;
      lfsr     <= SEED;
      q        <= '0;
      valid    <= 1'b0;
      reseeded <= 1'b0;
    end else begin
      state    <= state_n;
      tries    <= tries_n;
      lfsr     <= lfsr_n;
      q        <= q_n;
      valid    <= valid_n;
      reseeded <= reseeded_n;
    end
  end

endmodule

// File: tb/tb_lfsr_rand_range.sv
// Directed bench for lfsr_rand_range: default instance, a MAX_TRY=1 instance and a 16-bit instance.
module tb_lfsr_rand_range;

  logic clk = 1'b0;
  logic reset;

  logic       enable_a, req_a, seed_load_a;
  logic [6:0] seed_in_a;
  logic [1:0] q_a;
  logic       valid_a, busy_a, reseeded_a;
  logic [6:0] lfsr_a;

  logic       enable_b, req_b, seed_load_b;
  logic [6:0] seed_in_b;
  logic [1:0] q_b;
  logic       valid_b, busy_b, reseeded_b;
  logic [6:0] lfsr_b;

  logic        enable_c, req_c, seed_load_c;
  logic [15:0] seed_in_c;
  logic [2:0]  q_c;
  logic        valid_c, busy_c, reseeded_c;
  logic [15:0] lfsr_c;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lfsr_rand_range dut_a (
    .clk(clk), .reset(reset), .enable(enable_a), .req(req_a),
    .seed_load(seed_load_a), .seed_in(seed_in_a), .q(q_a), .valid(valid_a),
    .busy(busy_a), .reseeded(reseeded_a), .lfsr_state(lfsr_a)
  );

  lfsr_rand_range #(.MAX_TRY(1)) dut_b (
    .clk(clk), .reset(reset), .enable(enable_b), .req(req_b),
    .seed_load(seed_load_b), .seed_in(seed_in_b), .q(q_b), .valid(valid_b),
    .busy(busy_b), .reseeded(reseeded_b), .lfsr_state(lfsr_b)
  );

  lfsr_rand_range #(
    .WIDTH(16), .TAPS(16'hB400), .SEED(16'h0005), .OUT_W(3), .RANGE(5),
    .MAX_TRY(4), .RESEED_PAT(16'h0008)
  ) dut_c (
    .clk(clk), .reset(reset), .enable(enable_c), .req(req_c),
    .seed_load(seed_load_c), .seed_in(seed_in_c), .q(q_c), .valid(valid_c),
    .busy(busy_c), .reseeded(reseeded_c), .lfsr_state(lfsr_c)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic got;
    reset = 1'b0;
    enable_a = 0; req_a = 0; seed_load_a = 0; seed_in_a = '0;
    enable_b = 0; req_b = 0; seed_load_b = 0; seed_in_b = '0;
    enable_c = 0; req_c = 0; seed_load_c = 0; seed_in_c = '0;
    tick(); tick();

    // Reset state
    check("rst_q",        32'(q_a),        32'd0);
    check("rst_valid",    32'(valid_a),    32'd0);
    check("rst_busy",     32'(busy_a),     32'd0);
    check("rst_reseeded", 32'(reseeded_a), 32'd0);
    check("rst_lfsr",     32'(lfsr_a),     32'h05);
    check("rst_lfsr_c",   32'(lfsr_c),     32'h0005);
    reset = 1'b1;
    tick();

    // 1: first request accepts candidate 01 immediately
    req_a = 1; tick(); req_a = 0;
    check("s1_busy",  32'(busy_a),  32'd1);
    check("s1_valid0",32'(valid_a), 32'd0);
    check("s1_lfsr_hold", 32'(lfsr_a), 32'h05);
    tick();
    check("s1_valid", 32'(valid_a), 32'd1);
    check("s1_q",     32'(q_a),     32'd1);
    check("s1_lfsr",  32'(lfsr_a),  32'b0001011);
    check("s1_idle",  32'(busy_a),  32'd0);
    tick();
    check("s1_pulse", 32'(valid_a), 32'd0);
    check("s1_qhold", 32'(q_a),     32'd1);

    // 2: candidate 11 rejected, then 10 accepted
    req_a = 1; tick(); req_a = 0;
    check("s2_busy1", 32'(busy_a), 32'd1);
    tick();
    check("s2_busy2", 32'(busy_a),  32'd1);
    check("s2_noval", 32'(valid_a), 32'd0);
    check("s2_lfsr1", 32'(lfsr_a),  32'b0010110);
    tick();
    check("s2_valid", 32'(valid_a), 32'd1);
    check("s2_q",     32'(q_a),     32'd2);
    check("s2_busy3", 32'(busy_a),  32'd0);
    check("s2_lfsr2", 32'(lfsr_a),  32'b0101100);

    // 3: zero seed protection and reseed pattern
    seed_load_a = 1; seed_in_a = 7'd0; tick();
    check("s3_zero_seed", 32'(lfsr_a), 32'h05);
    seed_in_a = 7'b0001000; tick();
    check("s3_load8",    32'(lfsr_a),     32'h08);
    check("s3_load_nrs", 32'(reseeded_a), 32'd0);
    seed_load_a = 0; enable_a = 1; tick(); enable_a = 0;
    check("s3_reseed_lfsr", 32'(lfsr_a),     32'h05);
    check("s3_reseeded",    32'(reseeded_a), 32'd1);
    tick();
    check("s3_reseed_pulse", 32'(reseeded_a), 32'd0);
    check("s3_hold",         32'(lfsr_a),     32'h05);

    // 4: MAX_TRY=1 fallback clears the MSB of candidate 11
    seed_load_b = 1; seed_in_b = 7'b0000011; tick(); seed_load_b = 0;
    check("s4_load", 32'(lfsr_b), 32'h03);
    req_b = 1; tick(); req_b = 0;
    check("s4_busy", 32'(busy_b), 32'd1);
    tick();
    check("s4_valid", 32'(valid_b), 32'd1);
    check("s4_q",     32'(q_b),     32'd1);
    check("s4_idle",  32'(busy_b),  32'd0);
    check("s4_lfsr",  32'(lfsr_b),  32'b0000110);

    // 5: req held during GEN is not queued; req on valid cycle is accepted
    seed_load_a = 1; seed_in_a = 7'b0001011; tick(); seed_load_a = 0;
    req_a = 1; tick();
    check("s5_busy1", 32'(busy_a), 32'd1);
    tick(); req_a = 0;
    check("s5_busy2", 32'(busy_a),  32'd1);
    check("s5_noval", 32'(valid_a), 32'd0);
    tick();
    check("s5_valid", 32'(valid_a), 32'd1);
    check("s5_q",     32'(q_a),     32'd2);
    tick();
    check("s5_novalid_queued", 32'(valid_a), 32'd0);
    check("s5_noqueue_busy",   32'(busy_a),  32'd0);
    check("s5_qhold",          32'(q_a),     32'd2);
    tick();
    check("s5_still_idle", 32'(valid_a), 32'd0);
    check("s5_qhold2",     32'(q_a),     32'd2);
    // lfsr is 0101100 here; a fresh two-cycle request, then req raised on its valid cycle
    req_a = 1; tick(); req_a = 0;
    tick();
    check("s5_v2",  32'(valid_a), 32'd1);
    check("s5_q2",  32'(q_a),     32'd0);
    req_a = 1; tick(); req_a = 0;
    check("s5_accept_on_valid", 32'(busy_a),  32'd1);
    check("s5_q_unchanged",     32'(q_a),     32'd0);
    check("s5_v2_pulse",        32'(valid_a), 32'd0);
    tick();
    check("s5_v3",   32'(valid_a), 32'd1);
    check("s5_q3",   32'(q_a),     32'd1);

    // 6: reset in the middle of GEN
    req_a = 1; tick(); req_a = 0;
    check("s6_busy", 32'(busy_a), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("s6_q",     32'(q_a),     32'd0);
    check("s6_busy0", 32'(busy_a),  32'd0);
    check("s6_valid", 32'(valid_a), 32'd0);
    check("s6_lfsr",  32'(lfsr_a),  32'h05);
    tick(); tick();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("s6_no_valid", 32'(valid_a), 32'd0);
    end
    check("s6_lfsr_after", 32'(lfsr_a), 32'h05);

    // 7: 16-bit instance, many requests, outputs bounded and LFSR never zero
    enable_c = 1;
    for (int n = 0; n < 1000; n++) begin
      req_c = 1; tick(); req_c = 0;
      got = 1'b0;
      for (int w = 0; w < 8 && !got; w++) begin
        tick();
        if (valid_c) got = 1'b1;
      end
      check("s7_valid",   32'(got),            32'd1);
      check("s7_range",   32'(q_c < 3'd5),     32'd1);
      check("s7_nonzero", 32'(lfsr_c != 16'd0), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
